vga_scan_generator: RTL and testbench
=====================================

Name: vga_scan_generator

Overview:
- Drives the raster scan consumed by the sprite/graphics path and consumes the composed pixel it returns.
- Generates `vga_x_pos_o`/`vga_y_pos_o` at 640x480@60 Hz on the 25 MHz pixel clock.
- Samples the returned `RGB_i` and emits pipeline-aligned RGB, HSYNC, VSYNC and BLANK_N to the video DAC.
- Provides frame-boundary status (frame pulse, vblank level, frame counter) so the processor can time its sprite-register writes.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- PIPE_DLY, 2, clocks from position output to DAC output; legal range 1..8
- HS_POL, 0, active level of HSYNC
- VS_POL, 0, active level of VSYNC

Ports:
- vga_clk_i  in  1  pixel clock; one clock per pixel
- rst_n_i  in  1  asynchronous, active-low reset
- vga_x_pos_o  out  32  horizontal counter, zero-extended
- vga_y_pos_o  out  32  vertical counter, zero-extended
- RGB_i  in  24  composed pixel {R[23:16],G[15:8],B[7:0]} for the position issued PIPE_DLY-1 clocks earlier
- vga_r_o, vga_g_o, vga_b_o  out  8 each  DAC colour
- vga_hs_o  out  1  HSYNC, polarity HS_POL
- vga_vs_o  out  1  VSYNC, polarity VS_POL
- vga_blank_n_o  out  1  high during active video
- frame_start_o  out  1  single-clock pulse when position (0,0) is issued
- vblank_o  out  1  high while vga_y_pos_o >= V_ACTIVE
- frame_cnt_o  out  16  completed-frame counter

Behaviour:
- Totals: H_TOTAL = sum of H_* (800); V_TOTAL = sum of V_* (525).
- Counters h/v are registered. h increments every clock and wraps H_TOTAL-1 -> 0.
- v increments only on an h wrap and wraps V_TOTAL-1 -> 0 when h wraps with v = V_TOTAL-1.
- vga_x_pos_o/vga_y_pos_o are h/v directly, with no delay.
- Per-position decode (undelayed):
  - act = h < H_ACTIVE && v < V_ACTIVE
  - hs_act = H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC
  - vs_act = V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC (whole lines)
- act/hs_act/vs_act pass through a PIPE_DLY-deep shift register. Stage PIPE_DLY drives:
  - vga_hs_o = hs_act ? HS_POL : ~HS_POL
  - vga_vs_o likewise with VS_POL
  - vga_blank_n_o = act
- RGB output register: on each edge it loads RGB_i if the act value at stage PIPE_DLY-1 (the raw act when PIPE_DLY=1) is 1, else 0x000000.
- Net alignment: a position shown on vga_x/y_pos_o at clock t appears on the DAC pins at clock t+PIPE_DLY, together with its own sync and blank values.
- Upstream contract: the renderer returns RGB_i for position P exactly PIPE_DLY-1 clocks after P is issued (PIPE_DLY=2 covers the one-clock sprite ROM read).
- frame_start_o = 1 exactly in the clock where h=0 and v=0. It is undelayed, for processor sync.
- vblank_o is combinational from v, undelayed.
- frame_cnt_o increments by 1 on the clock where the counters wrap (H_TOTAL-1, V_TOTAL-1) -> (0,0). It wraps 0xFFFF -> 0.
- Reset (asynchronous assert, any time including mid-line or mid-frame):
  - h=v=0; every delay stage cleared to act=0, hs_act=0, vs_act=0.
  - RGB outputs 0; hs/vs at inactive level; blank_n 0; frame_cnt 0.
  - frame_start_o reads 1 while in reset, because the counters are at (0,0); benches ignore it during reset.
- After reset release: first clock presents (0,0) and counting resumes from there. The first PIPE_DLY DAC clocks are blank.
- Delayed HSYNC/VSYNC edges may cross a line or frame boundary; no glitches, every output registered except pos, vblank and frame_start.

Test Plan:
- Release reset, run one line, PIPE_DLY=2 -> vga_hs_o goes low at clock 658 after release for exactly 96 clocks; x wraps 799->0 with y 0->1.
- Run 420000 clocks -> frame_start_o pulses at clocks 0 and 420000 only; frame_cnt_o=1; vga_vs_o low for exactly 1600 clocks starting at the line-490 boundary +2.
- Model renderer returning RGB_i = {x[7:0], y[7:0], 0xA5} one clock after issue -> pixel (5,3) appears at DAC as 0x0503A5 with blank_n=1, two clocks after issue.
- Hold RGB_i = 0xFFFFFF -> DAC outputs 0x000000 whenever blank_n=0, i.e. x>=640 or y>=480 positions; 0xFFFFFF elsewhere.
- Assert rst_n_i at x=300,y=200 for 3 clocks -> immediately pos=0, RGB=0, hs=vs=1, blank_n=0; frame_cnt_o=0; restart from (0,0) after release.
- PIPE_DLY=1 build, RGB_i driven combinationally from pos -> pixel for (639,479) appears one clock after issue; blank_n falls on next clock.

Source files
------------

// File: rtl/vga_scan_generator_if.sv
// rtl/vga_scan_generator_if.sv - renderer link: raster position out, composed pixel back
//
// Purpose: bundles the scan position issued by the generator and the pixel the
// sprite/graphics path returns for it.
// Ports (signals):
//   vga_x_pos_o  32  horizontal counter, zero-extended (generator -> renderer)
//   vga_y_pos_o  32  vertical counter, zero-extended   (generator -> renderer)
//   RGB_i        24  composed pixel {R,G,B}            (renderer -> generator)
// Modports: master = scan generator, slave = renderer.
interface vga_scan_generator_if;
  logic [31:0] vga_x_pos_o;
  logic [31:0] vga_y_pos_o;
  logic [23:0] RGB_i;

  modport master (output vga_x_pos_o, output vga_y_pos_o, input RGB_i);
  modport slave  (input vga_x_pos_o, input vga_y_pos_o, output RGB_i);
endinterface

// File: rtl/vga_scan_generator.sv
// rtl/vga_scan_generator.sv - 640x480@60 raster scan generator with pipeline-aligned DAC outputs
//
// Purpose: counts pixels/lines, issues the position to the renderer, samples the
// returned pixel and drives RGB/HSYNC/VSYNC/BLANK_N delayed by PIPE_DLY clocks so
// that every pixel leaves together with its own sync and blank values.
// Ports:
//   vga_clk_i      in   pixel clock, one clock per pixel
//   rst_n_i        in   asynchronous active-low reset
//   scan           if   master: vga_x_pos_o/vga_y_pos_o out, RGB_i in
//   vga_r/g/b_o    out  8 each, DAC colour (0 outside active video)
//   vga_hs_o       out  HSYNC, active level HS_POL
//   vga_vs_o       out  VSYNC, active level VS_POL
//   vga_blank_n_o  out  high during active video
//   frame_start_o  out  high while position (0,0) is issued
//   vblank_o       out  high while the line counter is past the visible lines
//   frame_cnt_o    out  16-bit completed-frame counter
module vga_scan_generator #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter int   PIPE_DLY = 2,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0
) (
  input  logic                 vga_clk_i,
  input  logic                 rst_n_i,
  vga_scan_generator_if.master scan,
  output logic [7:0]           vga_r_o,
  output logic [7:0]           vga_g_o,
  output logic [7:0]           vga_b_o,
  output logic                 vga_hs_o,
  output logic                 vga_vs_o,
  output logic                 vga_blank_n_o,
  output logic                 frame_start_o,
  output logic                 vblank_o,
  output logic [15:0]          frame_cnt_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEGIN   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END     = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEGIN   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END     = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic [15:0]   frame_cnt;
  logic          line_end;
  logic          frame_end;

  assign line_end  = (h == H_LAST);
  assign frame_end = line_end && (v == V_LAST);

  always_ff @(posedge vga_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      h         <= '0;
      v         <= '0;
      frame_cnt <= '0;
    end else begin
      h <= line_end ? '0 : h + 1'b1;
      if (line_end) begin
        v <= (v == V_LAST) ? '0 : v + 1'b1;
      end
      if (frame_end) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

  assign scan.vga_x_pos_o = {{(32 - HW){1'b0}}, h};
  assign scan.vga_y_pos_o = {{(32 - VW){1'b0}}, v};
  assign frame_start_o    = (h == '0) && (v == '0);
  assign vblank_o         = (v >= V_ACT_END);
  assign frame_cnt_o      = frame_cnt;

  // Undelayed decode of the position currently being issued.
  logic act;
  logic hs_act;
  logic vs_act;

  assign act    = (h < H_ACT_END) && (v < V_ACT_END);
  assign hs_act = (h >= HS_BEGIN) && (h < HS_END);
  assign vs_act = (v >= VS_BEGIN) && (v < VS_END);

  // Index k-1 holds the decode of the position issued k clocks ago.
  logic [PIPE_DLY-1:0] act_q;
  logic [PIPE_DLY-1:0] hs_q;
  logic [PIPE_DLY-1:0] vs_q;

  always_ff @(posedge vga_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      act_q <= '0;
      hs_q  <= '0;
      vs_q  <= '0;
    end else begin
      act_q[0] <= act;
      hs_q[0]  <= hs_act;
      vs_q[0]  <= vs_act;
      for (int i = 1; i < PIPE_DLY; i++) begin
        act_q[i] <= act_q[i-1];
        hs_q[i]  <= hs_q[i-1];
        vs_q[i]  <= vs_q[i-1];
      end
    end
  end

  // RGB_i arrives PIPE_DLY-1 clocks after issue, so it is gated by the act bit
  // that is one stage short of the DAC stage; the RGB register adds the last clock.
  logic rgb_gate;

  if (PIPE_DLY == 1) begin : g_gate_raw
    assign rgb_gate = act;
  end else begin : g_gate_stage
    assign rgb_gate = act_q[PIPE_DLY-2];
  end

  logic [23:0] rgb_q;

  always_ff @(posedge vga_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rgb_q <= '0;
    end else begin
      rgb_q <= rgb_gate ? scan.RGB_i : 24'h000000;
    end
  end

  assign vga_r_o       = rgb_q[23:16];
  assign vga_g_o       = rgb_q[15:8];
  assign vga_b_o       = rgb_q[7:0];
  assign vga_blank_n_o = act_q[PIPE_DLY-1];
  // Polarity is a constant, so these follow their registers without glitches.
  assign vga_hs_o      = hs_q[PIPE_DLY-1] ? HS_POL : ~HS_POL;
  assign vga_vs_o      = vs_q[PIPE_DLY-1] ? VS_POL : ~VS_POL;

endmodule

// File: tb/tb_vga_scan_generator.sv
// tb/tb_vga_scan_generator.sv - directed bench for vga_scan_generator (PIPE_DLY=2 and PIPE_DLY=1 builds)
module tb_vga_scan_generator;

  // Full horizontal timing; vertical timing shortened so whole frames fit the run.
  localparam int VA    = 6;
  localparam int VF    = 2;
  localparam int VSW   = 2;
  localparam int VB    = 2;
  localparam int HT    = 800;
  localparam int VT    = VA + VF + VSW + VB;
  localparam int FRAME = HT * VT;

  logic clk = 1'b0;
  always #20 clk = ~clk;

  logic rst_a;
  logic rst_b;
  logic hold_white;

  vga_scan_generator_if scan_a ();
  vga_scan_generator_if scan_b ();

  logic [7:0]  r_a, g_a, b_a, r_b, g_b, b_b;
  logic        hs_a, vs_a, blank_a, fs_a, vbl_a;
  logic        hs_b, vs_b, blank_b, fs_b, vbl_b;
  logic [15:0] fc_a, fc_b;

  vga_scan_generator #(
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB), .PIPE_DLY(2)
  ) dut_a (
    .vga_clk_i(clk), .rst_n_i(rst_a), .scan(scan_a),
    .vga_r_o(r_a), .vga_g_o(g_a), .vga_b_o(b_a),
    .vga_hs_o(hs_a), .vga_vs_o(vs_a), .vga_blank_n_o(blank_a),
    .frame_start_o(fs_a), .vblank_o(vbl_a), .frame_cnt_o(fc_a)
  );

  vga_scan_generator #(
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB), .PIPE_DLY(1)
  ) dut_b (
    .vga_clk_i(clk), .rst_n_i(rst_b), .scan(scan_b),
    .vga_r_o(r_b), .vga_g_o(g_b), .vga_b_o(b_b),
    .vga_hs_o(hs_b), .vga_vs_o(vs_b), .vga_blank_n_o(blank_b),
    .frame_start_o(fs_b), .vblank_o(vbl_b), .frame_cnt_o(fc_b)
  );

  // Renderer with a one-clock ROM read for the PIPE_DLY=2 build.
  always @(posedge clk)
    scan_a.RGB_i <= hold_white ? 24'hFFFFFF
                               : {scan_a.vga_x_pos_o[7:0], scan_a.vga_y_pos_o[7:0], 8'hA5};

  // Combinational renderer for the PIPE_DLY=1 build.
  assign scan_b.RGB_i = {scan_b.vga_x_pos_o[7:0], scan_b.vga_y_pos_o[7:0], 8'h5A};

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests = n_tests + 1;
    if (obs !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int hs_first, hs_cnt, hsb_first, vs_first, vs_cnt, fs_n;
    int fs_at [0:3];
    int err_blank, err_hs, err_vs, err_rgb;
    int px, py;
    bit found;

    hs_first = -1; hs_cnt = 0; hsb_first = -1; vs_first = -1; vs_cnt = 0; fs_n = 0;
    for (int i = 0; i < 4; i++) fs_at[i] = -1;
    err_blank = 0; err_hs = 0; err_vs = 0; err_rgb = 0;
    found = 1'b0;

    rst_a = 1'b0;
    rst_b = 1'b0;
    hold_white = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_x",      scan_a.vga_x_pos_o, 32'd0);
    check("rst_y",      scan_a.vga_y_pos_o, 32'd0);
    check("rst_rgb",    {r_a, g_a, b_a}, 32'h0);
    check("rst_hs",     hs_a, 1'b1);
    check("rst_vs",     vs_a, 1'b1);
    check("rst_blank",  blank_a, 1'b0);
    check("rst_fcnt",   fc_a, 16'd0);
    check("rst_vblank", vbl_a, 1'b0);

    // Release both builds together; the sample taken here is clock 0.
    rst_a = 1'b1;
    rst_b = 1'b1;
    for (int c = 0; c <= 2 * FRAME; c++) begin
      if (c > 0) @(negedge clk);
      if (c < HT && !hs_a) begin
        if (hs_first < 0) hs_first = c;
        hs_cnt++;
      end
      if (c < HT && !hs_b && hsb_first < 0) hsb_first = c;
      if (c < FRAME && !vs_a) begin
        if (vs_first < 0) vs_first = c;
        vs_cnt++;
      end
      if (fs_a) begin
        if (fs_n < 4) fs_at[fs_n] = c;
        fs_n++;
      end
      case (c)
        0: begin
          check("c0_blank", blank_a, 1'b0);
          check("c0_rgb",   {r_a, g_a, b_a}, 32'h0);
        end
        1: begin
          check("c1_blank", blank_a, 1'b0);
          check("c1_rgb",   {r_a, g_a, b_a}, 32'h0);
        end
        2: begin
          check("c2_blank", blank_a, 1'b1);
          check("c2_rgb",   {r_a, g_a, b_a}, 32'h0000A5);
        end
        799: begin
          check("x_799", scan_a.vga_x_pos_o, 32'd799);
          check("y_799", scan_a.vga_y_pos_o, 32'd0);
        end
        800: begin
          check("x_wrap", scan_a.vga_x_pos_o, 32'd0);
          check("y_inc",  scan_a.vga_y_pos_o, 32'd1);
        end
        2407: begin
          check("pix_5_3_rgb",   {r_a, g_a, b_a}, 32'h0503A5);
          check("pix_5_3_blank", blank_a, 1'b1);
        end
        4639: begin
          check("b_x_639", scan_b.vga_x_pos_o, 32'd639);
          check("b_y_5",   scan_b.vga_y_pos_o, 32'd5);
        end
        4640: begin
          check("b_last_rgb",   {r_b, g_b, b_b}, 32'h7F055A);
          check("b_last_blank", blank_b, 1'b1);
        end
        4641: begin
          check("b_fall_blank", blank_b, 1'b0);
          check("b_fall_rgb",   {r_b, g_b, b_b}, 32'h0);
        end
        4799: check("vblank_4799", vbl_a, 1'b0);
        4800: check("vblank_4800", vbl_a, 1'b1);
        FRAME - 1: check("fcnt_before", fc_a, 16'd0);
        FRAME:     check("fcnt_one",    fc_a, 16'd1);
        2 * FRAME: check("fcnt_two",    fc_a, 16'd2);
        default: ;
      endcase
    end

    check("hs_first",    hs_first, 32'd658);
    check("hs_width",    hs_cnt, 32'd96);
    check("b_hs_first",  hsb_first, 32'd657);
    check("vs_first",    vs_first, 32'd6402);
    check("vs_width",    vs_cnt, 32'd1600);
    check("fs_count",    fs_n, 32'd3);
    check("fs_at0",      fs_at[0], 32'd0);
    check("fs_at1",      fs_at[1], FRAME);
    check("fs_at2",      fs_at[2], 2 * FRAME);

    // White renderer over a full frame: DAC colour must track blank_n, and
    // blank/sync must match the position issued two clocks earlier.
    hold_white = 1'b1;
    for (int c = 2 * FRAME + 1; c <= 3 * FRAME; c++) begin
      @(negedge clk);
      px = (c - 2) % HT;
      py = ((c - 2) / HT) % VT;
      if (blank_a !== (px < 640 && py < VA)) err_blank++;
      if (hs_a !== !(px >= 656 && px < 752)) err_hs++;
      if (vs_a !== !(py >= VA + VF && py < VA + VF + VSW)) err_vs++;
      if (c >= 2 * FRAME + 2 && {r_a, g_a, b_a} !== (blank_a ? 24'hFFFFFF : 24'h000000)) err_rgb++;
    end
    check("white_blank_errs", err_blank, 32'd0);
    check("white_hs_errs",    err_hs, 32'd0);
    check("white_vs_errs",    err_vs, 32'd0);
    check("white_rgb_errs",   err_rgb, 32'd0);

    // Mid-frame asynchronous reset at (300,3).
    for (int k = 0; k < 2 * FRAME && !found; k++) begin
      @(negedge clk);
      if (scan_a.vga_x_pos_o == 32'd300 && scan_a.vga_y_pos_o == 32'd3) found = 1'b1;
    end
    check("mid_found", found, 1'b1);
    check("mid_fcnt_pre", fc_a, 16'd3);
    rst_a = 1'b0;
    #1;
    check("mid_x",     scan_a.vga_x_pos_o, 32'd0);
    check("mid_y",     scan_a.vga_y_pos_o, 32'd0);
    check("mid_rgb",   {r_a, g_a, b_a}, 32'h0);
    check("mid_hs",    hs_a, 1'b1);
    check("mid_vs",    vs_a, 1'b1);
    check("mid_blank", blank_a, 1'b0);
    check("mid_fcnt",  fc_a, 16'd0);
    repeat (3) @(negedge clk);
    check("mid_hold_x", scan_a.vga_x_pos_o, 32'd0);
    rst_a = 1'b1;
    check("rel_x0", scan_a.vga_x_pos_o, 32'd0);
    @(negedge clk);
    check("rel_x1", scan_a.vga_x_pos_o, 32'd1);
    check("rel_y0", scan_a.vga_y_pos_o, 32'd0);
    check("rel_blank", blank_a, 1'b0);
    @(negedge clk);
    check("rel_blank_on", blank_a, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
